// File: rtl/stack_ctrl.sv
// Stack sequencer: drives StackPtr controls and the scratch-RAM port for
// PUSH/POP/PEEK/LDSP/CLR commands, tracking depth and sticky over/underflow flags.
module stack_ctrl #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op_code,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              op_ready,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_data,
    input  logic [ADDR_W-1:0] sp_val,
    output logic              sp_rst,
    output logic              sp_ld,
    output logic              sp_incr,
    output logic              sp_decr,
    output logic [ADDR_W-1:0] sp_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W:0]   depth,
    output logic              empty,
    output logic              full,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_PEEK = 3'd3;
    localparam logic [2:0] OP_LDSP = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_WR, S_RD, S_CAP, S_LDSP, S_CLR, S_DONE, S_ERR
    } state_t;

    state_t              r_state, w_next;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W:0]     r_depth;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_ovf, r_unf;
    logic                w_accept, w_empty, w_full;
    logic [ADDR_W-1:0]   w_ld_sp;
    logic [ADDR_W:0]     w_ld_depth;

    assign w_empty    = (r_depth == '0);
    assign w_full     = (r_depth == FULL_DEPTH);
    assign w_accept   = op_valid & op_ready;
    assign w_ld_sp    = r_data[ADDR_W-1:0];
    // Downward-growing stack: words held = distance from SP up to the wrap at 0.
    assign w_ld_depth = {1'b0, {ADDR_W{1'b0}} - w_ld_sp};

    assign depth    = r_depth;
    assign empty    = w_empty;
    assign full     = w_full;
    assign err_ovf  = r_ovf;
    assign err_unf  = r_unf;
    assign rsp_data = r_rsp_data;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    case (op_code)
                        OP_NOP:          w_next = S_DONE;
                        OP_PUSH:         w_next = w_full  ? S_ERR : S_PUSH_WR;
                        OP_POP, OP_PEEK: w_next = w_empty ? S_ERR : S_RD;
                        OP_LDSP:         w_next = S_LDSP;
                        OP_CLR:          w_next = S_CLR;
                        default:         w_next = S_ERR;
                    endcase
                end
            end
            S_RD:    w_next = S_CAP;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        op_ready  = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        sp_rst    = 1'b0;
        sp_ld     = 1'b0;
        sp_incr   = 1'b0;
        sp_decr   = 1'b0;
        sp_din    = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (rst) begin
            sp_rst = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: op_ready = 1'b1;
                S_PUSH_WR: begin
                    mem_addr  = sp_val - 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = r_data;
                    sp_decr   = 1'b1;
                    rsp_valid = 1'b1;
                end
                S_RD: mem_addr = sp_val;
                S_CAP: begin
                    sp_incr   = (r_op == OP_POP);
                    rsp_valid = 1'b1;
                end
                S_LDSP: begin
                    sp_ld     = 1'b1;
                    sp_din    = w_ld_sp;
                    rsp_valid = 1'b1;
                end
                S_CLR: begin
                    sp_rst    = 1'b1;
                    rsp_valid = 1'b1;
                end
                S_DONE: rsp_valid = 1'b1;
                S_ERR: begin
                    rsp_valid = 1'b1;
                    rsp_err   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_depth    <= '0;
            r_rsp_data <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_PUSH_WR: r_depth <= r_depth + 1'b1;
                S_CAP: begin
                    r_rsp_data <= mem_rdata;
                    if (r_op == OP_POP) r_depth <= r_depth - 1'b1;
                end
                S_LDSP: r_depth <= w_ld_depth;
                S_CLR: begin
                    r_depth <= '0;
                    r_ovf   <= 1'b0;
                    r_unf   <= 1'b0;
                end
                // ERR is only reached for PUSH-when-full, POP/PEEK-when-empty or illegal codes.
                S_ERR: begin
                    if (r_op == OP_PUSH) r_ovf <= 1'b1;
                    if (r_op == OP_POP || r_op == OP_PEEK) r_unf <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op   <= op_code;
            r_data <= op_wdata;
        end
    end

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural StackPtr and synchronous
// scratch RAM attached.
module tb_stack_ctrl;
    localparam int DW = 10;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [2:0]    op_code = '0;
    logic [DW-1:0] op_wdata = '0;
    logic          op_ready, rsp_valid, rsp_err;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] sp_val = '0;
    logic          sp_rst, sp_ld, sp_incr, sp_decr;
    logic [AW-1:0] sp_din, mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW:0]   depth;
    logic          empty, full, err_ovf, err_unf;

    stack_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_wdata(op_wdata),
        .op_ready(op_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .sp_val(sp_val), .sp_rst(sp_rst), .sp_ld(sp_ld), .sp_incr(sp_incr), .sp_decr(sp_decr),
        .sp_din(sp_din), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .depth(depth), .empty(empty), .full(full),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    int            n_we = 0, n_rsp = 0, n_acc = 0, n_multi = 0;
    logic [AW-1:0] last_wa = '0;
    logic [DW-1:0] last_wd = '0;

    always @(posedge clk) begin
        if (sp_rst)       sp_val <= '0;
        else if (sp_ld)   sp_val <= sp_din;
        else if (sp_incr) sp_val <= sp_val + 1'b1;
        else if (sp_decr) sp_val <= sp_val - 1'b1;
        mem_rdata <= ram[mem_addr];
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
            n_we    <= n_we + 1;
            last_wa <= mem_addr;
            last_wd <= mem_wdata;
        end
        if (rsp_valid) n_rsp <= n_rsp + 1;
        if (op_valid && op_ready && !rst) n_acc <= n_acc + 1;
    end

    always @(negedge clk)
        if ($countones({sp_rst, sp_ld, sp_incr, sp_decr}) > 1) n_multi <= n_multi + 1;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response cycle.
    task automatic send(input logic [2:0] c, input logic [DW-1:0] d, output int lat, output logic err);
        int n;
        n = 0;
        while (!op_ready && n < 20) begin @(negedge clk); n++; end
        op_valid = 1'b1; op_code = c; op_wdata = d;
        @(posedge clk);
        #1 op_valid = 1'b0;
        lat = 0; err = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rsp_valid && lat < 10);
        if (!rsp_valid) begin
            chk("rsp_timeout", 32'(lat), 0);
            lat = -1;
        end
        err = rsp_err;
        @(negedge clk);
    endtask

    int          lat, acc0, rsp0, we0, n_bad;
    logic        err;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sp_rst", 32'(sp_rst), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_op_ready", 32'(op_ready), 1);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_depth", 32'(depth), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_flags", 32'({err_ovf, err_unf}), 0);
        chk("rst_sp", 32'(sp_val), 0);

        send(3'd1, 10'h155, lat, err);
        chk("push1_lat", 32'(lat), 1);
        chk("push1_err", 32'(err), 0);
        chk("push1_addr", 32'(last_wa), 32'hFF);
        chk("push1_data", 32'(last_wd), 32'h155);
        send(3'd1, 10'h2AA, lat, err);
        chk("push2_lat", 32'(lat), 1);
        chk("push2_addr", 32'(last_wa), 32'hFE);
        chk("push2_data", 32'(last_wd), 32'h2AA);
        chk("push2_sp", 32'(sp_val), 32'hFE);
        chk("push2_depth", 32'(depth), 2);

        send(3'd2, 10'h0, lat, err);
        chk("pop1_lat", 32'(lat), 2);
        chk("pop1_data", 32'(rsp_data), 32'h2AA);
        send(3'd2, 10'h0, lat, err);
        chk("pop2_lat", 32'(lat), 2);
        chk("pop2_data", 32'(rsp_data), 32'h155);
        chk("pop2_sp", 32'(sp_val), 0);
        chk("pop2_depth", 32'(depth), 0);
        chk("pop2_empty", 32'(empty), 1);

        send(3'd2, 10'h0, lat, err);
        chk("unf_lat", 32'(lat), 1);
        chk("unf_err", 32'(err), 1);
        chk("unf_flag", 32'(err_unf), 1);
        chk("unf_sp", 32'(sp_val), 0);
        send(3'd0, 10'h0, lat, err);
        chk("nop_lat", 32'(lat), 1);
        chk("nop_err", 32'(err), 0);
        chk("unf_sticky", 32'(err_unf), 1);
        send(3'd5, 10'h0, lat, err);
        chk("clr_err", 32'(err), 0);
        chk("clr_flag", 32'(err_unf), 0);
        chk("clr_sp", 32'(sp_val), 0);
        send(3'd6, 10'h0, lat, err);
        chk("ill_err", 32'(err), 1);
        chk("ill_flags", 32'({err_ovf, err_unf}), 0);

        n_bad = 0;
        for (int i = 0; i < 256; i++) begin
            send(3'd1, DW'(i * 3 + 1), lat, err);
            if (err || lat != 1) n_bad++;
        end
        chk("fill_bad", 32'(n_bad), 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_depth", 32'(depth), 256);
        we0 = n_we;
        send(3'd1, 10'h3FF, lat, err);
        chk("ovf_err", 32'(err), 1);
        chk("ovf_flag", 32'(err_ovf), 1);
        chk("ovf_no_we", 32'(n_we), 32'(we0));
        send(3'd3, 10'h0, lat, err);
        chk("peek_lat", 32'(lat), 2);
        chk("peek_data", 32'(rsp_data), 32'h2FE);
        chk("peek_depth", 32'(depth), 256);

        send(3'd4, 10'h0F0, lat, err);
        chk("ldsp_sp", 32'(sp_val), 32'hF0);
        chk("ldsp_depth", 32'(depth), 16);
        send(3'd4, 10'h000, lat, err);
        chk("ldsp0_depth", 32'(depth), 0);
        chk("ldsp0_empty", 32'(empty), 1);

        send(3'd1, 10'h0AB, lat, err);
        chk("pre_abort_depth", 32'(depth), 1);
        acc0 = n_acc; rsp0 = n_rsp;
        op_valid = 1'b1; op_code = 3'd2; op_wdata = '0;
        @(negedge clk);
        chk("busy_rd_ready", 32'(op_ready), 0);
        @(negedge clk);
        chk("busy_cap_ready", 32'(op_ready), 0);
        rst = 1'b1;
        #1;
        chk("abort_incr", 32'(sp_incr), 0);
        chk("abort_rsp", 32'(rsp_valid), 0);
        chk("abort_sp_rst", 32'(sp_rst), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(op_ready), 1);
        chk("abort_sp", 32'(sp_val), 0);
        chk("abort_depth", 32'(depth), 0);
        chk("abort_no_rsp", 32'(n_rsp), 32'(rsp0));
        chk("abort_one_acc", 32'(n_acc), 32'(acc0 + 1));
        op_valid = 1'b0;
        @(negedge clk);
        chk("sp_ctrl_onehot", 32'(n_multi), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
